// File: rtl/eth_idma_desc_sched.sv
// eth_idma_desc_sched: TX/RX descriptor queues, round-robin issue to one iDMA
// request channel, bounded in-flight count, in-order response matching.
// Ports: clk_i/rst_ni, en_i; tx_desc_*/rx_desc_* descriptor handshakes;
//        idma_req_* request out; idma_rsp_* response in; completion counters,
//        outstanding_o, done/err irq pulses, busy_o.

// Generic synchronous FIFO with registered storage and a head-of-queue read port.
// Latency: a push at edge N is visible on data_o/empty_o after edge N.
// Backpressure: push while full and pop while empty are ignored.
module eth_idma_desc_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push, do_pop;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == FullCnt);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  // Storage needs no reset: the head is only consumed when non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Descriptor scheduler between the Ethernet register file and the iDMA backend.
// Latency: descriptor accepted at edge N can be on idma_req_* after edge N+1.
// Backpressure: queues stall descriptors when full; the held request waits on idma_req_ready_i.
module eth_idma_desc_sched #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned DescFifoDepth  = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  en_i,
  input  logic                                  tx_desc_valid_i,
  output logic                                  tx_desc_ready_o,
  input  logic [AddrWidth-1:0]                  tx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                 tx_desc_len_i,
  input  logic                                  rx_desc_valid_i,
  output logic                                  rx_desc_ready_o,
  input  logic [AddrWidth-1:0]                  rx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                 rx_desc_len_i,
  output logic                                  idma_req_valid_o,
  input  logic                                  idma_req_ready_i,
  output logic [AddrWidth-1:0]                  idma_req_addr_o,
  output logic [TFLenWidth-1:0]                 idma_req_len_o,
  output logic                                  idma_req_dir_o,
  input  logic                                  idma_rsp_valid_i,
  output logic                                  idma_rsp_ready_o,
  input  logic                                  idma_rsp_error_i,
  output logic [CntWidth-1:0]                   tx_done_cnt_o,
  output logic [CntWidth-1:0]                   rx_done_cnt_o,
  output logic [CntWidth-1:0]                   err_cnt_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  done_irq_o,
  output logic                                  err_irq_o,
  output logic                                  busy_o
);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

  typedef struct packed {
    logic [AddrWidth-1:0]  addr;
    logic [TFLenWidth-1:0] len;
  } desc_t;

  desc_t tx_wr, rx_wr, tx_head, rx_head;
  logic  tx_full, tx_empty, rx_full, rx_empty;
  logic  tx_push, rx_push, tx_zero, rx_zero;
  logic  tag_dir, tag_empty, tag_full;
  logic  rr_rx;      // 1: RX has priority on the next contended grant
  logic  grant_rx, load, rsp_hs, rsp_err;
  logic [1:0] err_inc;

  assign tx_wr = '{addr: tx_desc_addr_i, len: tx_desc_len_i};
  assign rx_wr = '{addr: rx_desc_addr_i, len: rx_desc_len_i};

  assign tx_desc_ready_o = !tx_full;
  assign rx_desc_ready_o = !rx_full;

  // Zero-length descriptors complete the handshake but are dropped as errors.
  assign tx_zero = tx_desc_valid_i && !tx_full && (tx_desc_len_i == '0);
  assign rx_zero = rx_desc_valid_i && !rx_full && (rx_desc_len_i == '0);
  assign tx_push = tx_desc_valid_i && !tx_full && (tx_desc_len_i != '0);
  assign rx_push = rx_desc_valid_i && !rx_full && (rx_desc_len_i != '0);

  // A lone non-empty queue wins; otherwise the RR pointer decides.
  assign grant_rx = !rx_empty && (tx_empty || rr_rx);
  // tag_full is implied by the outstanding limit; kept as a safety interlock.
  assign load = (!idma_req_valid_o || idma_req_ready_i) && en_i &&
                (outstanding_o < MaxOut) && !tag_full && (!tx_empty || !rx_empty);

  assign idma_rsp_ready_o = !tag_empty;
  assign rsp_hs  = idma_rsp_valid_i && !tag_empty;
  assign rsp_err = rsp_hs && idma_rsp_error_i;
  assign err_inc = {1'b0, tx_zero} + {1'b0, rx_zero} + {1'b0, rsp_err};

  assign busy_o = !tx_empty || !rx_empty || (outstanding_o != '0);

  eth_idma_desc_fifo #(.Width($bits(desc_t)), .Depth(DescFifoDepth)) u_tx_fifo (
    .clk_i, .rst_ni,
    .push_i (tx_push),
    .data_i (tx_wr),
    .pop_i  (load && !grant_rx),
    .data_o (tx_head),
    .empty_o(tx_empty),
    .full_o (tx_full)
  );

  eth_idma_desc_fifo #(.Width($bits(desc_t)), .Depth(DescFifoDepth)) u_rx_fifo (
    .clk_i, .rst_ni,
    .push_i (rx_push),
    .data_i (rx_wr),
    .pop_i  (load && grant_rx),
    .data_o (rx_head),
    .empty_o(rx_empty),
    .full_o (rx_full)
  );

  // Direction of every reserved transfer, in issue order; iDMA answers in order.
  eth_idma_desc_fifo #(.Width(1), .Depth(MaxOutstanding)) u_tag_fifo (
    .clk_i, .rst_ni,
    .push_i (load),
    .data_i (grant_rx),
    .pop_i  (rsp_hs),
    .data_o (tag_dir),
    .empty_o(tag_empty),
    .full_o (tag_full)
  );

  // Request holding slot: payload only changes on a load, so it stays stable while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idma_req_valid_o <= 1'b0;
      idma_req_addr_o  <= '0;
      idma_req_len_o   <= '0;
      idma_req_dir_o   <= 1'b0;
      rr_rx            <= 1'b0;
    end else if (load) begin
      idma_req_valid_o <= 1'b1;
      idma_req_addr_o  <= grant_rx ? rx_head.addr : tx_head.addr;
      idma_req_len_o   <= grant_rx ? rx_head.len  : tx_head.len;
      idma_req_dir_o   <= grant_rx;
      rr_rx            <= !grant_rx;
    end else if (idma_req_ready_i) begin
      idma_req_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
      tx_done_cnt_o <= '0;
      rx_done_cnt_o <= '0;
      err_cnt_o     <= '0;
      done_irq_o    <= 1'b0;
      err_irq_o     <= 1'b0;
    end else begin
      case ({load, rsp_hs})
        2'b10:   outstanding_o <= outstanding_o + 1'b1;
        2'b01:   outstanding_o <= outstanding_o - 1'b1;
        default: outstanding_o <= outstanding_o;
      endcase
      if (rsp_hs && !idma_rsp_error_i && !tag_dir) tx_done_cnt_o <= tx_done_cnt_o + 1'b1;
      if (rsp_hs && !idma_rsp_error_i &&  tag_dir) rx_done_cnt_o <= rx_done_cnt_o + 1'b1;
      err_cnt_o  <= err_cnt_o + CntWidth'(err_inc);
      done_irq_o <= rsp_hs && !idma_rsp_error_i;
      err_irq_o  <= rsp_err || tx_zero || rx_zero;
    end
  end
endmodule

// File: tb/tb_eth_idma_desc_sched.sv
// Directed bench for eth_idma_desc_sched with default parameters
// (DescFifoDepth=4, MaxOutstanding=4). Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_eth_idma_desc_sched;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        tx_desc_valid_i = 1'b0, rx_desc_valid_i = 1'b0;
  logic        tx_desc_ready_o, rx_desc_ready_o;
  logic [31:0] tx_desc_addr_i = '0, rx_desc_addr_i = '0;
  logic [31:0] tx_desc_len_i = '0, rx_desc_len_i = '0;
  logic        idma_req_valid_o, idma_req_ready_i = 1'b0;
  logic [31:0] idma_req_addr_o, idma_req_len_o;
  logic        idma_req_dir_o;
  logic        idma_rsp_valid_i = 1'b0, idma_rsp_ready_o, idma_rsp_error_i = 1'b0;
  logic [15:0] tx_done_cnt_o, rx_done_cnt_o, err_cnt_o;
  logic [2:0]  outstanding_o;
  logic        done_irq_o, err_irq_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int loads;

  eth_idma_desc_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .tx_desc_valid_i(tx_desc_valid_i), .tx_desc_ready_o(tx_desc_ready_o),
    .tx_desc_addr_i(tx_desc_addr_i), .tx_desc_len_i(tx_desc_len_i),
    .rx_desc_valid_i(rx_desc_valid_i), .rx_desc_ready_o(rx_desc_ready_o),
    .rx_desc_addr_i(rx_desc_addr_i), .rx_desc_len_i(rx_desc_len_i),
    .idma_req_valid_o(idma_req_valid_o), .idma_req_ready_i(idma_req_ready_i),
    .idma_req_addr_o(idma_req_addr_o), .idma_req_len_o(idma_req_len_o),
    .idma_req_dir_o(idma_req_dir_o),
    .idma_rsp_valid_i(idma_rsp_valid_i), .idma_rsp_ready_o(idma_rsp_ready_o),
    .idma_rsp_error_i(idma_rsp_error_i),
    .tx_done_cnt_o(tx_done_cnt_o), .rx_done_cnt_o(rx_done_cnt_o),
    .err_cnt_o(err_cnt_o), .outstanding_o(outstanding_o),
    .done_irq_o(done_irq_o), .err_irq_o(err_irq_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    tick(); tick();
    chk("rst_req_valid", idma_req_valid_o, 0);
    chk("rst_req_addr", idma_req_addr_o, 0);
    chk("rst_req_len", idma_req_len_o, 0);
    chk("rst_req_dir", idma_req_dir_o, 0);
    chk("rst_rsp_ready", idma_rsp_ready_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_irqs", {done_irq_o, err_irq_o}, 0);
    chk("rst_tx_ready", tx_desc_ready_o, 1);
    rst_ni = 1'b1;
    tick();

    // ---------------- fairness: 4 TX + 4 RX preloaded, en low ----------------
    tx_desc_valid_i = 1'b1;
    rx_desc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_desc_addr_i = 32'h2000 + 32'(i) * 32'h10;
      tx_desc_len_i  = 32'(i) * 8 + 8;
      rx_desc_addr_i = 32'h3000 + 32'(i) * 32'h10;
      rx_desc_len_i  = 32'(i) * 8 + 8;
      tick();
    end
    chk("full_tx_ready", tx_desc_ready_o, 0);
    chk("full_rx_ready", rx_desc_ready_o, 0);
    chk("en_low_no_valid", idma_req_valid_o, 0);
    chk("preload_busy", busy_o, 1);
    tx_desc_valid_i = 1'b0;
    rx_desc_valid_i = 1'b0;
    en_i = 1'b1;
    idma_req_ready_i = 1'b1;
    idma_rsp_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_valid", idma_req_valid_o, 1);
      chk("fair_dir", idma_req_dir_o, k % 2);
      chk("fair_addr", idma_req_addr_o,
          ((k % 2) ? 32'h3000 : 32'h2000) + 32'(k / 2) * 32'h10);
    end
    tick(); tick();
    idma_rsp_valid_i = 1'b0;
    idma_req_ready_i = 1'b0;
    chk("fair_tx_cnt", tx_done_cnt_o, 4);
    chk("fair_rx_cnt", rx_done_cnt_o, 4);
    chk("fair_outstanding", outstanding_o, 0);
    chk("fair_rsp_ready", idma_rsp_ready_o, 0);
    chk("fair_idle_valid", idma_req_valid_o, 0);
    tick();
    chk("fair_busy", busy_o, 0);

    // ---------------- single TX ----------------
    tx_desc_valid_i = 1'b1;
    tx_desc_addr_i = 32'h1000;
    tx_desc_len_i = 32'd64;
    tick();
    tx_desc_valid_i = 1'b0;
    chk("single_not_yet", idma_req_valid_o, 0);
    tick();
    chk("single_valid", idma_req_valid_o, 1);
    chk("single_dir", idma_req_dir_o, 0);
    chk("single_addr", idma_req_addr_o, 32'h1000);
    chk("single_len", idma_req_len_o, 64);
    chk("single_outstanding", outstanding_o, 1);
    idma_req_ready_i = 1'b1;
    tick();
    idma_req_ready_i = 1'b0;
    chk("single_hs_valid", idma_req_valid_o, 0);
    chk("single_inflight", outstanding_o, 1);
    chk("single_rsp_ready", idma_rsp_ready_o, 1);
    idma_rsp_valid_i = 1'b1;
    idma_rsp_error_i = 1'b0;
    tick();
    idma_rsp_valid_i = 1'b0;
    chk("single_tx_cnt", tx_done_cnt_o, 5);
    chk("single_done_irq", done_irq_o, 1);
    chk("single_out_zero", outstanding_o, 0);
    tick();
    chk("single_irq_pulse", done_irq_o, 0);
    chk("single_busy", busy_o, 0);

    // ---------------- backpressure and en_i low with a held request ----------------
    tx_desc_valid_i = 1'b1;
    tx_desc_addr_i = 32'h4000;
    tx_desc_len_i = 32'd100;
    tick();
    tx_desc_valid_i = 1'b0;
    tick();
    chk("bp_valid", idma_req_valid_o, 1);
    en_i = 1'b0;
    rx_desc_valid_i = 1'b1;
    rx_desc_addr_i = 32'h5000;
    rx_desc_len_i = 32'd200;
    for (int i = 0; i < 10; i++) begin
      tick();
      rx_desc_valid_i = 1'b0;
      chk("bp_hold_valid", idma_req_valid_o, 1);
      chk("bp_hold_addr", idma_req_addr_o, 32'h4000);
      chk("bp_hold_len", idma_req_len_o, 100);
      chk("bp_hold_dir", idma_req_dir_o, 0);
    end
    idma_req_ready_i = 1'b1;
    tick();
    idma_req_ready_i = 1'b0;
    chk("en_low_held_done", idma_req_valid_o, 0);
    chk("en_low_out", outstanding_o, 1);
    tick();
    chk("en_low_blocks", idma_req_valid_o, 0);
    idma_rsp_valid_i = 1'b1;
    tick();
    idma_rsp_valid_i = 1'b0;
    chk("bp_tx_cnt", tx_done_cnt_o, 6);
    chk("bp_busy_queued", busy_o, 1);
    en_i = 1'b1;
    tick();
    chk("rx_valid", idma_req_valid_o, 1);
    chk("rx_dir", idma_req_dir_o, 1);
    chk("rx_addr", idma_req_addr_o, 32'h5000);
    chk("rx_len", idma_req_len_o, 200);

    // ---------------- error response on RX, then zero-length TX ----------------
    idma_req_ready_i = 1'b1;
    tick();
    idma_req_ready_i = 1'b0;
    idma_rsp_valid_i = 1'b1;
    idma_rsp_error_i = 1'b1;
    tick();
    idma_rsp_valid_i = 1'b0;
    idma_rsp_error_i = 1'b0;
    chk("err_cnt_rsp", err_cnt_o, 1);
    chk("err_irq", err_irq_o, 1);
    chk("err_no_done_irq", done_irq_o, 0);
    chk("err_rx_cnt", rx_done_cnt_o, 4);
    tick();
    chk("err_irq_pulse", err_irq_o, 0);
    idma_req_ready_i = 1'b1;
    tx_desc_valid_i = 1'b1;
    tx_desc_addr_i = 32'h6000;
    tx_desc_len_i = 32'd0;
    tick();
    tx_desc_valid_i = 1'b0;
    chk("zlen_err_cnt", err_cnt_o, 2);
    chk("zlen_err_irq", err_irq_o, 1);
    chk("zlen_busy", busy_o, 0);
    tick();
    chk("zlen_no_req", idma_req_valid_o, 0);
    chk("zlen_irq_pulse", err_irq_o, 0);

    // ---------------- outstanding limit ----------------
    en_i = 1'b0;
    tx_desc_valid_i = 1'b1;
    rx_desc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_desc_addr_i = 32'h9000 + 32'(i);
      tx_desc_len_i = 32'd4;
      rx_desc_addr_i = 32'hA000 + 32'(i);
      rx_desc_len_i = 32'd4;
      tick();
    end
    tx_desc_valid_i = 1'b0;
    rx_desc_valid_i = 1'b0;
    en_i = 1'b1;
    loads = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (idma_req_valid_o) loads++;
    end
    chk("lim_loads", loads, 4);
    chk("lim_outstanding", outstanding_o, 4);
    chk("lim_valid_off", idma_req_valid_o, 0);
    idma_rsp_valid_i = 1'b1;
    tick();
    idma_rsp_valid_i = 1'b0;
    chk("lim_rsp_out", outstanding_o, 3);
    chk("lim_rsp_no_issue", idma_req_valid_o, 0);
    tick();
    chk("lim_fifth_valid", idma_req_valid_o, 1);
    chk("lim_fifth_out", outstanding_o, 4);
    idma_req_ready_i = 1'b0;

    // ---------------- asynchronous reset with transfers in flight ----------------
    rst_ni = 1'b0;
    #2;
    chk("arst_valid", idma_req_valid_o, 0);
    chk("arst_addr", idma_req_addr_o, 0);
    chk("arst_outstanding", outstanding_o, 0);
    chk("arst_tx_cnt", tx_done_cnt_o, 0);
    chk("arst_rx_cnt", rx_done_cnt_o, 0);
    chk("arst_err_cnt", err_cnt_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rsp_ready", idma_rsp_ready_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // RR pointer is back on TX after reset
    tx_desc_valid_i = 1'b1;
    rx_desc_valid_i = 1'b1;
    tx_desc_addr_i = 32'h7000;
    tx_desc_len_i = 32'd16;
    rx_desc_addr_i = 32'h8000;
    rx_desc_len_i = 32'd16;
    tick();
    tx_desc_valid_i = 1'b0;
    rx_desc_valid_i = 1'b0;
    tick();
    chk("post_rst_valid", idma_req_valid_o, 1);
    chk("post_rst_dir", idma_req_dir_o, 0);
    chk("post_rst_addr", idma_req_addr_o, 32'h7000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
